// File: rtl/hazard_md.sv
// hazard_md -- hazard detection and forwarding unit for the 5-stage MIPS core.
//
// Generates the forwarding mux selects for the branch comparator in D and the
// ALU operands in E. It also produces the stall and flush controls for the
// load-use, branch-operand and HI/LO-pending hazards. A small scoreboard
// tracks an in-flight MULT/DIV so that dependent MULT/DIV/MFHI/MFLO
// instructions wait in D. A saturating counter records the number of stalled
// cycles for performance monitoring.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   rsD, rtD, rsE, rtE      source register specifiers in D and E
//   writeregE/M/W           destination specifiers per stage
//   regwriteE/M/W           destination write enables per stage
//   memtoregE/M             load instruction in E / M
//   branchD, pcsrcD         branch in D, branch in D resolved taken
//   mdopD, hiloreadD        MULT/DIV or MFHI/MFLO in D
//   mdstartE                MULT/DIV issuing to the unit from E
//   perfclr                 synchronous clear of stallcount
//   forwardaD, forwardbD    forward ALUoutM to the branch comparator
//   forwardaE, forwardbE    ALU operand select: 00 regfile, 01 resultW, 10 ALUoutM
//   stallF, stallD          hold PC / hold D register
//   flushD, flushE          clear D / E register
//   mdbusy                  HI/LO result still pending
//   stallcount              saturating count of stalled cycles

module hazard_md #(
    parameter int REGBITS = 5,
    parameter int MDLAT   = 4,
    parameter int CNTW    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REGBITS-1:0] rsD,
    input  logic [REGBITS-1:0] rtD,
    input  logic [REGBITS-1:0] rsE,
    input  logic [REGBITS-1:0] rtE,
    input  logic [REGBITS-1:0] writeregE,
    input  logic [REGBITS-1:0] writeregM,
    input  logic [REGBITS-1:0] writeregW,
    input  logic               regwriteE,
    input  logic               regwriteM,
    input  logic               regwriteW,
    input  logic               memtoregE,
    input  logic               memtoregM,
    input  logic               branchD,
    input  logic               pcsrcD,
    input  logic               mdopD,
    input  logic               hiloreadD,
    input  logic               mdstartE,
    input  logic               perfclr,
    output logic               forwardaD,
    output logic               forwardbD,
    output logic [1:0]         forwardaE,
    output logic [1:0]         forwardbE,
    output logic               stallF,
    output logic               stallD,
    output logic               flushD,
    output logic               flushE,
    output logic               mdbusy,
    output logic [CNTW-1:0]    stallcount
);

    typedef enum logic {IDLE, BUSY} mdState_t;

    mdState_t  mdState;
    logic [3:0] mdCnt;
    logic       lwStall;
    logic       branchStall;
    logic       mdStall;
    logic       srcDInE;
    logic       srcDInM;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] satInc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    // ALU operand select: M has priority over W because it is the younger value.
    function automatic logic [1:0] fwdSel(input logic [REGBITS-1:0] src);
        if (src != '0 && src == writeregM && regwriteM)
            return 2'b10;
        else if (src != '0 && src == writeregW && regwriteW)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
        forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;
        forwardaE = fwdSel(rsE);
        forwardbE = fwdSel(rtE);
    end

    // A D-stage source matches the destination currently in E or M.
    assign srcDInE = (writeregE != '0) && (writeregE == rsD || writeregE == rtD);
    assign srcDInM = (writeregM != '0) && (writeregM == rsD || writeregM == rtD);

    // The load destination is writeregE (not rtE) so the check stays correct
    // whatever register-select encoding produced it.
    assign lwStall     = memtoregE && regwriteE && srcDInE;
    // The comparator only takes ALUoutM, so an ALU result still in E, or load
    // data not yet back from memory in M, must be waited for.
    assign branchStall = branchD && ((regwriteE && srcDInE) || (memtoregM && srcDInM));
    assign mdStall     = mdbusy && (mdopD || hiloreadD);

    assign stallD = lwStall || branchStall || mdStall;
    assign stallF = stallD;
    assign flushE = stallD;
    // A stalled branch has not really been resolved yet, so it must not flush.
    assign flushD = pcsrcD && !stallD;

    assign mdbusy = (mdState == BUSY);

    // MULT/DIV scoreboard: busy for exactly MDLAT cycles after issue.
    // A new issue reloads the counter even if one is already in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdState <= IDLE;
            mdCnt   <= '0;
        end else if (mdstartE) begin
            mdState <= BUSY;
            mdCnt   <= 4'(MDLAT);
        end else if (mdState == BUSY) begin
            mdCnt <= mdCnt - 4'd1;
            if (mdCnt == 4'd1)
                mdState <= IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stallcount <= '0;
        else if (perfclr)
            stallcount <= '0;
        else if (stallD)
            stallcount <= satInc(stallcount);
    end

    // The pipeline holds a MULT/DIV in D while the unit is busy, so a second
    // issue during busy indicates a broken upstream stall.
    mdNoReissue: assert property (@(posedge clk) disable iff (!reset) !(mdstartE && mdbusy));

endmodule

// File: tb/tb_hazard_md.sv
// Scoreboard bench for hazard_md (MDLAT=4, CNTW=4 so saturation is quick).
// Each test fills a stimulus list with hand-derived expected output vectors.
// Every cycle one stimulus is driven and its expectation is pushed to the
// scoreboard. At the following negative edge the expectation is popped and
// compared with the DUT outputs.

module tb_hazard_md;

    localparam int RB = 5;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [RB-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic branchD, pcsrcD, mdopD, hiloreadD, mdstartE, perfclr;
    logic forwardaD, forwardbD, stallF, stallD, flushD, flushE, mdbusy;
    logic [1:0] forwardaE, forwardbE;
    logic [CW-1:0] stallcount;

    hazard_md #(.REGBITS(RB), .MDLAT(4), .CNTW(CW)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .pcsrcD(pcsrcD), .mdopD(mdopD), .hiloreadD(hiloreadD),
        .mdstartE(mdstartE), .perfclr(perfclr),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .mdbusy(mdbusy), .stallcount(stallcount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RB-1:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic rwE, rwM, rwW, mtrE, mtrM, br, pcsrc, mdop, hilo, mdstart, pclr, rstn;
    } stim_t;

    typedef struct {
        string       name;
        logic [14:0] val;
        logic [14:0] mask;
    } exp_t;

    localparam logic [14:0] MALL   = 15'h7fff;
    localparam logic [14:0] MNOCNT = 15'h7ff0;

    stim_t stimQ[$];
    exp_t  expQ[$];
    exp_t  sb[$];
    int    nTests = 0;
    int    nFail  = 0;

    // {fwdaD, fwdbD, fwdaE, fwdbE, stallF, stallD, flushD, flushE, mdbusy, stallcount}
    function automatic logic [14:0] mk(input logic fad, input logic fbd,
                                       input logic [1:0] fae, input logic [1:0] fbe,
                                       input logic sf, input logic sd, input logic fd,
                                       input logic fe, input logic mb,
                                       input logic [CW-1:0] cnt);
        return {fad, fbd, fae, fbe, sf, sd, fd, fe, mb, cnt};
    endfunction

    function automatic logic [14:0] obs();
        return {forwardaD, forwardbD, forwardaE, forwardbE, stallF, stallD,
                flushD, flushE, mdbusy, stallcount};
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.rstn = 1'b1;
        return s;
    endfunction

    function automatic void add(input stim_t s, input string n,
                                input logic [14:0] v, input logic [14:0] m);
        exp_t e;
        e.name = n;
        e.val  = v & m;
        e.mask = m;
        stimQ.push_back(s);
        expQ.push_back(e);
    endfunction

    task automatic apply(input stim_t s);
        rsD = s.rsD; rtD = s.rtD; rsE = s.rsE; rtE = s.rtE;
        writeregE = s.wE; writeregM = s.wM; writeregW = s.wW;
        regwriteE = s.rwE; regwriteM = s.rwM; regwriteW = s.rwW;
        memtoregE = s.mtrE; memtoregM = s.mtrM;
        branchD = s.br; pcsrcD = s.pcsrc; mdopD = s.mdop; hiloreadD = s.hilo;
        mdstartE = s.mdstart; perfclr = s.pclr; reset = s.rstn;
    endtask

    task automatic test_reset();
        stim_t s;
        exp_t e;
        s = idle(); s.rstn = 1'b0;
        add(s, "reset_idle", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MALL);
        s = idle(); s.rstn = 1'b0; s.rsE = 5; s.wM = 5; s.rwM = 1;
        add(s, "reset_comb_fwd", mk(0,0,2'b10,2'b00,0,0,0,0,0,4'd0), MALL);
        s = idle();
        add(s, "reset_release", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MALL);
        while (stimQ.size() > 0) begin
            @(posedge clk); #1;
            apply(stimQ.pop_front());
            sb.push_back(expQ.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            nTests++;
            if ((obs() & e.mask) !== e.val) begin
                nFail++;
                $display("FAIL %s: got %h want %h (mask %h)", e.name, obs() & e.mask, e.val, e.mask);
            end
        end
    endtask

    task automatic test_forward();
        stim_t s;
        exp_t e;
        s = idle(); s.rsE = 5; s.wM = 5; s.rwM = 1; s.wW = 5; s.rwW = 1;
        add(s, "fwdaE_m_over_w", mk(0,0,2'b10,2'b00,0,0,0,0,0,4'd0), MALL);
        s.rsE = 0;
        add(s, "fwdaE_rs0", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MALL);
        s = idle(); s.wM = 0; s.rwM = 1; s.wW = 0; s.rwW = 1;
        add(s, "fwdaE_r0_writer", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MALL);
        s = idle(); s.rsE = 5; s.wM = 5; s.rwM = 0; s.wW = 5; s.rwW = 1;
        add(s, "fwdaE_w_noregwrM", mk(0,0,2'b01,2'b00,0,0,0,0,0,4'd0), MALL);
        s = idle(); s.rsE = 5; s.wM = 6; s.rwM = 1; s.wW = 5; s.rwW = 1;
        add(s, "fwdaE_w_only", mk(0,0,2'b01,2'b00,0,0,0,0,0,4'd0), MALL);
        s = idle(); s.rtE = 7; s.wM = 7; s.rwM = 1;
        add(s, "fwdbE_m", mk(0,0,2'b00,2'b10,0,0,0,0,0,4'd0), MALL);
        s = idle(); s.rtE = 9; s.wW = 9; s.rwW = 1;
        add(s, "fwdbE_w", mk(0,0,2'b00,2'b01,0,0,0,0,0,4'd0), MALL);
        s.rwW = 0;
        add(s, "fwdbE_none", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MALL);
        s = idle(); s.rsD = 4; s.rtD = 4; s.wM = 4; s.rwM = 1;
        add(s, "fwdD_both", mk(1,1,2'b00,2'b00,0,0,0,0,0,4'd0), MALL);
        s = idle(); s.rsD = 4; s.rtD = 11; s.wM = 11; s.rwM = 1;
        add(s, "fwdbD_only", mk(0,1,2'b00,2'b00,0,0,0,0,0,4'd0), MALL);
        s = idle(); s.wM = 0; s.rwM = 1;
        add(s, "fwdD_r0", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MALL);
        s = idle(); s.rsD = 4; s.wM = 4; s.rwM = 0;
        add(s, "fwdaD_noregwr", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MALL);
        while (stimQ.size() > 0) begin
            @(posedge clk); #1;
            apply(stimQ.pop_front());
            sb.push_back(expQ.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            nTests++;
            if ((obs() & e.mask) !== e.val) begin
                nFail++;
                $display("FAIL %s: got %h want %h (mask %h)", e.name, obs() & e.mask, e.val, e.mask);
            end
        end
    endtask

    task automatic test_loaduse();
        stim_t s;
        exp_t e;
        s = idle(); s.mtrE = 1; s.rwE = 1; s.wE = 8; s.rtD = 8; s.rtE = 3; s.pcsrc = 1;
        add(s, "lw_stall_noflushD", mk(0,0,2'b00,2'b00,1,1,0,1,0,4'd0), MALL);
        s = idle(); s.rwE = 1; s.wE = 8; s.rtD = 8;
        add(s, "lw_cleared", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd1), MALL);
        s = idle(); s.mtrE = 1; s.rwE = 1; s.wE = 0;
        add(s, "lw_r0", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd1), MALL);
        s = idle(); s.mtrE = 1; s.rwE = 1; s.wE = 8; s.rtE = 8; s.rsD = 2; s.rtD = 3;
        add(s, "lw_uses_writeregE", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd1), MALL);
        s = idle(); s.mtrE = 1; s.rwE = 1; s.wE = 8; s.rsD = 8;
        add(s, "lw_rs_match", mk(0,0,2'b00,2'b00,1,1,0,1,0,4'd1), MALL);
        s = idle(); s.pcsrc = 1;
        add(s, "taken_flushD", mk(0,0,2'b00,2'b00,0,0,1,0,0,4'd2), MALL);
        while (stimQ.size() > 0) begin
            @(posedge clk); #1;
            apply(stimQ.pop_front());
            sb.push_back(expQ.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            nTests++;
            if ((obs() & e.mask) !== e.val) begin
                nFail++;
                $display("FAIL %s: got %h want %h (mask %h)", e.name, obs() & e.mask, e.val, e.mask);
            end
        end
    endtask

    task automatic test_branch();
        stim_t s;
        exp_t e;
        s = idle(); s.br = 1; s.rsD = 3; s.rwE = 1; s.wE = 3;
        add(s, "br_alu_in_E", mk(0,0,2'b00,2'b00,1,1,0,1,0,4'd2), MALL);
        s = idle(); s.br = 1; s.rsD = 3; s.mtrM = 1; s.wM = 3; s.rwM = 1;
        add(s, "br_load_in_M", mk(1,0,2'b00,2'b00,1,1,0,1,0,4'd3), MALL);
        s = idle(); s.br = 1; s.rsD = 3; s.wM = 3; s.rwM = 1; s.pcsrc = 1;
        add(s, "br_fwd_taken", mk(1,0,2'b00,2'b00,0,0,1,0,0,4'd4), MALL);
        s = idle(); s.rsD = 3; s.rwE = 1; s.wE = 3;
        add(s, "nobr_alu_in_E", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd4), MALL);
        s = idle(); s.br = 1; s.rtD = 6; s.mtrM = 1; s.wM = 6;
        add(s, "br_load_rt", mk(0,0,2'b00,2'b00,1,1,0,1,0,4'd4), MALL);
        s = idle(); s.br = 1; s.rwE = 1; s.mtrM = 1;
        add(s, "br_r0", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd5), MALL);
        while (stimQ.size() > 0) begin
            @(posedge clk); #1;
            apply(stimQ.pop_front());
            sb.push_back(expQ.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            nTests++;
            if ((obs() & e.mask) !== e.val) begin
                nFail++;
                $display("FAIL %s: got %h want %h (mask %h)", e.name, obs() & e.mask, e.val, e.mask);
            end
        end
    endtask

    task automatic test_mult();
        stim_t s;
        exp_t e;
        // hiloreadD held: stalled for exactly cycles 1..4
        s = idle(); s.hilo = 1; s.mdstart = 1;
        add(s, "md_issue", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MNOCNT);
        s.mdstart = 0;
        for (int c = 1; c <= 4; c++)
            add(s, $sformatf("md_hilo_busy_c%0d", c), mk(0,0,2'b00,2'b00,1,1,0,1,1,4'd0), MNOCNT);
        add(s, "md_hilo_done_c5", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MNOCNT);
        // only mdopD in cycle 2 stalls; a taken branch is suppressed meanwhile
        s = idle(); s.mdstart = 1;
        add(s, "md2_issue", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MNOCNT);
        s = idle();
        add(s, "md2_busy_c1", mk(0,0,2'b00,2'b00,0,0,0,0,1,4'd0), MNOCNT);
        s.mdop = 1; s.pcsrc = 1;
        add(s, "md2_mdop_c2", mk(0,0,2'b00,2'b00,1,1,0,1,1,4'd0), MNOCNT);
        s = idle();
        add(s, "md2_busy_c3", mk(0,0,2'b00,2'b00,0,0,0,0,1,4'd0), MNOCNT);
        add(s, "md2_busy_c4", mk(0,0,2'b00,2'b00,0,0,0,0,1,4'd0), MNOCNT);
        s.mdop = 1; s.hilo = 1; s.mdstart = 1;
        add(s, "md2_free_reissue_c5", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MNOCNT);
        s = idle(); s.hilo = 1;
        add(s, "md3_back_to_back", mk(0,0,2'b00,2'b00,1,1,0,1,1,4'd0), MNOCNT);
        s = idle();
        for (int c = 2; c <= 4; c++)
            add(s, $sformatf("md3_busy_c%0d", c), mk(0,0,2'b00,2'b00,0,0,0,0,1,4'd0), MNOCNT);
        add(s, "md3_done", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MNOCNT);
        while (stimQ.size() > 0) begin
            @(posedge clk); #1;
            apply(stimQ.pop_front());
            sb.push_back(expQ.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            nTests++;
            if ((obs() & e.mask) !== e.val) begin
                nFail++;
                $display("FAIL %s: got %h want %h (mask %h)", e.name, obs() & e.mask, e.val, e.mask);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t s;
        exp_t e;
        s = idle(); s.hilo = 1; s.mdstart = 1;
        add(s, "rst_issue", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MNOCNT);
        s.mdstart = 0;
        add(s, "rst_busy_c1", mk(0,0,2'b00,2'b00,1,1,0,1,1,4'd0), MNOCNT);
        s.rstn = 0;
        add(s, "rst_async_clear", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MALL);
        s.rstn = 1;
        add(s, "rst_released", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MALL);
        s.mdop = 1;
        add(s, "rst_no_stall", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MALL);
        while (stimQ.size() > 0) begin
            @(posedge clk); #1;
            apply(stimQ.pop_front());
            sb.push_back(expQ.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            nTests++;
            if ((obs() & e.mask) !== e.val) begin
                nFail++;
                $display("FAIL %s: got %h want %h (mask %h)", e.name, obs() & e.mask, e.val, e.mask);
            end
        end
    endtask

    task automatic test_counter();
        stim_t s;
        stim_t lw;
        exp_t e;
        lw = idle(); lw.mtrE = 1; lw.rwE = 1; lw.wE = 8; lw.rtD = 8;
        for (int k = 0; k < 20; k++)
            add(lw, $sformatf("cnt_k%0d", k),
                mk(0,0,2'b00,2'b00,1,1,0,1,0,(k > 15) ? 4'd15 : 4'(k)), MALL);
        s = idle();
        add(s, "cnt_saturated", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd15), MALL);
        s = lw; s.pclr = 1;
        add(s, "cnt_clr_with_stall", mk(0,0,2'b00,2'b00,1,1,0,1,0,4'd15), MALL);
        s = idle();
        add(s, "cnt_cleared", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MALL);
        add(lw, "cnt_restart", mk(0,0,2'b00,2'b00,1,1,0,1,0,4'd0), MALL);
        s = idle(); s.pclr = 1;
        add(s, "cnt_one", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd1), MALL);
        s = idle();
        add(s, "cnt_clr_alone", mk(0,0,2'b00,2'b00,0,0,0,0,0,4'd0), MALL);
        while (stimQ.size() > 0) begin
            @(posedge clk); #1;
            apply(stimQ.pop_front());
            sb.push_back(expQ.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            nTests++;
            if ((obs() & e.mask) !== e.val) begin
                nFail++;
                $display("FAIL %s: got %h want %h (mask %h)", e.name, obs() & e.mask, e.val, e.mask);
            end
        end
    endtask

    initial begin
        apply(idle());
        reset = 1'b0;
        test_reset();
        test_forward();
        test_loaduse();
        test_branch();
        test_mult();
        test_reset_mid();
        test_counter();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

endmodule

// File: doc/hazard_md.md
Name: hazard_md

Overview:
- Second-generation hazard/forwarding unit for the 5-stage pipelined MIPS core.
- Generalised in register-address width, and adds a multicycle MULT/DIV scoreboard for HI/LO, branch-taken flush of D, and a saturating stall-cycle counter.
- Sits beside the datapath.
- Drives forwarding muxes (D compare, E ALU), stall enables for F/D, and flushes for D/E.

Parameters:
REGBITS, 5, register-specifier width (register 0 hardwired zero)
MDLAT, 4, MULT/DIV latency in cycles after issue from E (legal 1..15)
CNTW, 16, width of stall-cycle counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
rsD, rtD  in  REGBITS  source specifiers in D
rsE, rtE  in  REGBITS  source specifiers in E
writeregE, writeregM, writeregW  in  REGBITS  destination specifiers per stage
regwriteE, regwriteM, regwriteW  in  1  destination write enables
memtoregE, memtoregM  in  1  load in E / M
branchD  in  1  any conditional branch (beq/bne) in D
pcsrcD  in  1  branch in D resolved taken
mdopD  in  1  MULT/DIV instruction in D
hiloreadD  in  1  MFHI/MFLO in D
mdstartE  in  1  MULT/DIV instruction in E (issues to unit this cycle)
perfclr  in  1  synchronous clear of stallcount
forwardaD, forwardbD  out  1  forward ALUoutM to branch comparator
forwardaE, forwardbE  out  2  00 reg file, 01 resultW, 10 ALUoutM
stallF, stallD  out  1  hold PC / hold D register
flushD, flushE  out  1  clear D / E register
mdbusy  out  1  HI/LO result pending
stallcount  out  CNTW  saturating count of stalled cycles

Behaviour:
- Forwarding (combinational):
  - Register 0 never forwards.
  - forwardaD = rsD!=0 & rsD==writeregM & regwriteM; forwardbD uses rtD in the same way.
  - forwardaE: 10 if rsE matches writeregM with regwriteM; else 01 if it matches writeregW with regwriteW; else 00. M has priority over W.
  - forwardbE: same rule using rtE.
- Load-use stall:
  - lwstall = memtoregE & regwriteE & writeregE!=0 & (writeregE==rsD | writeregE==rtD).
  - Uses writeregE, not rtE.
- Branch stall:
  - branchstall = branchD & [ (regwriteE & writeregE!=0 & writeregE∈{rsD,rtD}) | (memtoregM & writeregM!=0 & writeregM∈{rsD,rtD}) ].
- MULT/DIV scoreboard:
  - 4-bit down-counter mdcnt; mdbusy = (mdcnt != 0).
  - States: IDLE (mdcnt==0) and BUSY.
  - mdstartE at a rising edge loads mdcnt = MDLAT. Load wins over decrement.
  - Otherwise, if mdcnt!=0, mdcnt decrements by 1.
  - After issue, mdbusy is high for exactly MDLAT cycles. MFHI/MFLO may read in D in the first cycle mdbusy is low.
  - mdstall = mdbusy & (mdopD | hiloreadD).
  - mdstartE while mdbusy must not occur, since D is stalled; if it does, the counter reloads. The verifier flags it as an assertion.
- Stall/flush:
  - stallD = lwstall | branchstall | mdstall.
  - stallF = stallD; flushE = stallD.
  - flushD = pcsrcD & ~stallD. A branch is not resolved while stalled.
- stallcount:
  - perfclr at an edge sets it to 0. perfclr has priority.
  - Otherwise it increments by 1 on each edge where stallD=1.
  - It holds at all-ones (saturating, no wrap).
- Reset:
  - reset low asynchronously forces mdcnt=0, mdbusy=0, stallcount=0.
  - Combinational outputs then reflect inputs with mdbusy=0.
  - Reset mid-MULT abandons the pending result; no stall after release.

Test Plan:
- Forward priority: rsE=5, writeregM=5/regwriteM=1, writeregW=5/regwriteW=1 -> forwardaE=10. Same with rsE=0 -> forwardaE=00.
- Load-use: memtoregE=1, regwriteE=1, writeregE=8, rtD=8 -> stallF=stallD=flushE=1, flushD=0 even with pcsrcD=1. Next cycle memtoregE=0 -> all 0.
- Branch stall: branchD=1, rsD=3, regwriteE=1, writeregE=3 -> stallD=1. Next cycle memtoregM=1, writeregM=3 -> stallD=1. Then neither -> forwardaD per M match, stallD=0.
- MULT latency (MDLAT=4): mdstartE pulse at edge 0, hiloreadD=1 held -> mdbusy and stallD high for cycles 1-4, low from cycle 5. mdopD=1 during cycle 2 also stalls.
- Reset mid-operation: reset low during mdbusy at cycle 2 -> mdbusy=0, stallcount=0 immediately, no stall after release.
- Counter (CNTW=4): hold stallD=1 for 20 cycles -> stallcount=15 and holds. Assert perfclr together with stallD=1 -> stallcount=0.
